// File: rtl/lc3b_param_cache.sv
// Parametrised write-back, write-allocate, set-associative cache between the
// LC-3b 16-bit memory port and a line-wide physical memory, with tree PLRU.
module lc3b_param_cache #(
  parameter int unsigned NUM_SETS  = 8,
  parameter int unsigned WAYS      = 2,
  parameter int unsigned LINE_BITS = 128
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [15:0]          mem_address,
  input  logic                 mem_read,
  input  logic                 mem_write,
  input  logic [1:0]           mem_wmask,
  input  logic [15:0]          mem_wdata,
  output logic [15:0]          mem_rdata,
  output logic                 mem_resp,
  output logic [15:0]          pmem_address,
  output logic                 pmem_read,
  output logic                 pmem_write,
  output logic [LINE_BITS-1:0] pmem_wdata,
  input  logic [LINE_BITS-1:0] pmem_rdata,
  input  logic                 pmem_resp
);

  localparam int unsigned IDX    = $clog2(NUM_SETS);
  localparam int unsigned OFF    = $clog2(LINE_BITS / 8);
  localparam int unsigned TAG    = 16 - IDX - OFF;
  localparam int unsigned WORD_W = OFF - 1;
  localparam int unsigned WAY_W  = (WAYS > 1) ? $clog2(WAYS) : 1;
  localparam int unsigned PLRU_W = (WAYS > 1) ? WAYS - 1 : 1;

  typedef enum logic [1:0] {IDLE, WRITEBACK, FILL} state_t;

  state_t state_q, state_d;

  logic [LINE_BITS-1:0] data_q  [NUM_SETS][WAYS];
  logic [TAG-1:0]       tag_q   [NUM_SETS][WAYS];
  logic [WAYS-1:0]      valid_q [NUM_SETS];
  logic [WAYS-1:0]      dirty_q [NUM_SETS];
  logic [PLRU_W-1:0]    plru_q  [NUM_SETS];

  logic [WAY_W-1:0] vict_q;
  logic [TAG-1:0]   tag_l;
  logic [IDX-1:0]   idx_l;

  logic [TAG-1:0]    req_tag;
  logic [IDX-1:0]    req_idx;
  logic [WORD_W-1:0] req_word;
  logic              req;

  assign req_tag  = mem_address[15 -: TAG];
  assign req_idx  = mem_address[OFF +: IDX];
  assign req_word = mem_address[1 +: WORD_W];
  assign req      = mem_read | mem_write;

  logic                 hit;
  logic [WAY_W-1:0]     hit_way;
  logic [WAY_W-1:0]     victim;
  logic [WAY_W-1:0]     plru_vict;
  logic                 vict_dirty;
  logic                 found_inv;
  logic [2:0]           plru_cur;
  logic [2:0]           plru_hit;
  logic [1:0]           hw2;
  logic [LINE_BITS-1:0] hit_line;
  logic [LINE_BITS-1:0] merged_line;
  int unsigned          wbase;

  // Tag lookup, byte merge, victim choice and PLRU update for the current set
  always_comb begin
    hit       = 1'b0;
    hit_way   = '0;
    found_inv = 1'b0;
    victim    = '0;
    for (int w = 0; w < WAYS; w++) begin
      if (valid_q[req_idx][w] && (tag_q[req_idx][w] == req_tag)) begin
        hit     = 1'b1;
        hit_way = WAY_W'(w);
      end
    end
    wbase       = 32'(req_word) * 16;
    hit_line    = data_q[req_idx][hit_way];
    merged_line = hit_line;
    if (mem_wmask[0]) merged_line[wbase +: 8]     = mem_wdata[7:0];
    if (mem_wmask[1]) merged_line[wbase + 8 +: 8] = mem_wdata[15:8];

    // Bit set means the victim lies in the upper half of that subtree
    plru_cur = 3'(plru_q[req_idx]);
    case (WAYS)
      2:       plru_vict = WAY_W'(plru_cur[0]);
      4:       plru_vict = WAY_W'({plru_cur[0], plru_cur[0] ? plru_cur[2] : plru_cur[1]});
      default: plru_vict = '0;
    endcase
    for (int w = 0; w < WAYS; w++) begin
      if (!found_inv && !valid_q[req_idx][w]) begin
        found_inv = 1'b1;
        victim    = WAY_W'(w);
      end
    end
    if (!found_inv) victim = plru_vict;
    vict_dirty = valid_q[req_idx][victim] && dirty_q[req_idx][victim];

    hw2      = 2'(hit_way);
    plru_hit = plru_cur;
    if (WAYS == 2) begin
      plru_hit[0] = ~hw2[0];
    end else if (WAYS == 4) begin
      plru_hit[0] = ~hw2[1];
      if (hw2[1]) plru_hit[2] = ~hw2[0];
      else        plru_hit[1] = ~hw2[0];
    end
  end

  always_comb begin
    state_d      = state_q;
    mem_resp     = 1'b0;
    mem_rdata    = '0;
    pmem_read    = 1'b0;
    pmem_write   = 1'b0;
    pmem_address = '0;
    pmem_wdata   = '0;
    case (state_q)
      IDLE: begin
        if (req) begin
          if (hit) begin
            mem_resp  = 1'b1;
            mem_rdata = hit_line[wbase +: 16];
          end else begin
            state_d = vict_dirty ? WRITEBACK : FILL;
          end
        end
      end
      WRITEBACK: begin
        pmem_write   = 1'b1;
        pmem_address = {tag_q[idx_l][vict_q], idx_l, {OFF{1'b0}}};
        pmem_wdata   = data_q[idx_l][vict_q];
        if (pmem_resp) state_d = FILL;
      end
      FILL: begin
        pmem_read    = 1'b1;
        pmem_address = {tag_l, idx_l, {OFF{1'b0}}};
        if (pmem_resp) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Status bits, PLRU and the latched miss context
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int s = 0; s < NUM_SETS; s++) begin
        valid_q[s] <= '0;
        dirty_q[s] <= '0;
        plru_q[s]  <= '0;
      end
      vict_q <= '0;
      tag_l  <= '0;
      idx_l  <= '0;
    end else begin
      if (state_q == IDLE && req) begin
        if (hit) begin
          plru_q[req_idx] <= PLRU_W'(plru_hit);
          if (mem_write) dirty_q[req_idx][hit_way] <= 1'b1;
        end else begin
          vict_q <= victim;
          tag_l  <= req_tag;
          idx_l  <= req_idx;
        end
      end
      if (state_q == FILL && pmem_resp) begin
        valid_q[idx_l][vict_q] <= 1'b1;
        dirty_q[idx_l][vict_q] <= 1'b0;
      end
    end
  end

  // Data and tag arrays carry no reset
  always_ff @(posedge clk) begin
    if (!rst) begin
      if (state_q == IDLE && req && hit && mem_write)
        data_q[req_idx][hit_way] <= merged_line;
      if (state_q == FILL && pmem_resp) begin
        data_q[idx_l][vict_q] <= pmem_rdata;
        tag_q[idx_l][vict_q]  <= tag_l;
      end
    end
  end

endmodule
